ysyx_22041071_ex_stage: RTL and testbench

//  Execute stage of the 5-stage RV64 pipeline; consumes the ID/EX register outputs of the decode stage.

---
 rtl/ysyx_22041071_ex_stage.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_ysyx_22041071_ex_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_ex_stage.sv
// ----------------------------------------------------------------------------
// ysyx_22041071_ex_stage
// Execute stage of the 5-stage RV64 pipeline. Takes the ID/EX bundle from
// decode, computes the ALU / compare result, resolves conditional branches,
// runs a restoring iterative divider, and drives the registered EX/MEM bundle.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   valid4 / ready4     ID/EX handshake; ready4 low also stalls decode
//   PC4 .. BImm2        ID/EX bundle (PC, instr word, control, operands)
//   result              combinational result of the current EX instruction
//   rdest1_, reg_w_en3_ forwarding info back to decode
//   ready5 / valid5     EX/MEM handshake
//   PC5 .. ALU_res3     registered EX/MEM bundle
//   Brch_taken, BPC     registered one-cycle taken pulse and branch target
// ----------------------------------------------------------------------------
module ysyx_22041071_ex_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned DIV_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  // ID/EX bundle
  input  logic            valid4,
  output logic            ready4,
  input  logic [XLEN-1:0] PC4,
  input  logic [31:0]     Ins3,
  input  logic            Brch2,
  input  logic            MEM_W_en2,
  input  logic            WB_sel2,
  input  logic [4:0]      ALU_ctrl2,
  input  logic            reg_w_en2,
  input  logic [XLEN-1:0] rt_data1,
  input  logic [4:0]      rdest1,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [11:0]     BImm2,
  // forwarding to decode
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdest1_,
  output logic            reg_w_en3_,
  // EX/MEM bundle
  input  logic            ready5,
  output logic            valid5,
  output logic [XLEN-1:0] PC5,
  output logic [31:0]     Ins4,
  output logic            MEM_W_en3,
  output logic            WB_sel3,
  output logic            reg_w_en3,
  output logic [XLEN-1:0] rt_data2,
  output logic [4:0]      rdest3,
  output logic [XLEN-1:0] ALU_res3,
  // branch resolution
  output logic            Brch_taken,
  output logic [XLEN-1:0] BPC
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_ADDW = 5'd10;
  localparam logic [4:0] OP_SUBW = 5'd11;
  localparam logic [4:0] OP_SLLW = 5'd12;
  localparam logic [4:0] OP_SRLW = 5'd13;
  localparam logic [4:0] OP_SRAW = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_EQ   = 5'd16;
  localparam logic [4:0] OP_NE   = 5'd17;
  localparam logic [4:0] OP_LT   = 5'd18;
  localparam logic [4:0] OP_GE   = 5'd19;
  localparam logic [4:0] OP_LTU  = 5'd20;
  localparam logic [4:0] OP_GEU  = 5'd21;
  localparam logic [4:0] OP_DIV  = 5'd22;
  localparam logic [4:0] OP_DIVU = 5'd23;
  localparam logic [4:0] OP_REM  = 5'd24;
  localparam logic [4:0] OP_REMU = 5'd25;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Sign-extend a 32-bit W-op result to XLEN
  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] w);
    return {{(XLEN-32){w[31]}}, w};
  endfunction

  // ------------------------------------------------------------------
  // Combinational ALU
  // ------------------------------------------------------------------
  logic [5:0]      sh;
  logic [4:0]      shw;
  logic [XLEN-1:0] prod;
  logic [XLEN-1:0] alu_res;
  logic            div_op;
  logic            div_signed;
  logic            div_rem_op;
  logic            div_go;

  assign sh   = src_b[5:0];
  assign shw  = src_b[4:0];
  assign prod = src_a * src_b;

  assign div_op     = (ALU_ctrl2 >= OP_DIV) && (ALU_ctrl2 <= OP_REMU);
  assign div_signed = (ALU_ctrl2 == OP_DIV) || (ALU_ctrl2 == OP_REM);
  assign div_rem_op = (ALU_ctrl2 == OP_REM) || (ALU_ctrl2 == OP_REMU);
  // Divide by zero bypasses the iterative divider and finishes in one cycle
  assign div_go     = (DIV_EN != 0) && div_op && (src_b != '0);

  always_comb begin
    alu_res = '0;
    case (ALU_ctrl2)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLL:  alu_res = src_a << sh;
      OP_SLT:  alu_res = XLEN'($signed(src_a) < $signed(src_b));
      OP_SLTU: alu_res = XLEN'(src_a < src_b);
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SRL:  alu_res = src_a >> sh;
      OP_SRA:  alu_res = XLEN'($signed(src_a) >>> sh);
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_ADDW: alu_res = sext_w(32'(src_a[31:0] + src_b[31:0]));
      OP_SUBW: alu_res = sext_w(32'(src_a[31:0] - src_b[31:0]));
      OP_SLLW: alu_res = sext_w(32'(src_a[31:0] << shw));
      OP_SRLW: alu_res = sext_w(32'(src_a[31:0] >> shw));
      OP_SRAW: alu_res = sext_w(32'($signed(src_a[31:0]) >>> shw));
      OP_MUL:  alu_res = prod;
      OP_EQ:   alu_res = XLEN'(src_a == src_b);
      OP_NE:   alu_res = XLEN'(src_a != src_b);
      OP_LT:   alu_res = XLEN'($signed(src_a) < $signed(src_b));
      OP_GE:   alu_res = XLEN'($signed(src_a) >= $signed(src_b));
      OP_LTU:  alu_res = XLEN'(src_a < src_b);
      OP_GEU:  alu_res = XLEN'(src_a >= src_b);
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        // Only the divide-by-zero case is produced here; nonzero divisors go
        // through the FSM and this value is never selected.
        if ((DIV_EN != 0) && (src_b == '0)) begin
          alu_res = div_rem_op ? src_a : '1;
        end
      end
      default: alu_res = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Divider datapath (restoring, one quotient bit per cycle)
  // ------------------------------------------------------------------
  logic [XLEN-1:0]  div_q;
  logic [XLEN-1:0]  div_r;
  logic [XLEN-1:0]  div_b;
  logic             div_neg_q;
  logic             div_neg_r;
  logic             div_is_rem;
  logic [CNT_W-1:0] div_cnt;
  logic             div_start;

  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_trial;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;
  logic [XLEN-1:0]  div_res;

  assign a_abs = (div_signed && src_a[XLEN-1]) ? (-src_a) : src_a;
  assign b_abs = (div_signed && src_b[XLEN-1]) ? (-src_b) : src_b;

  // Shift the next dividend bit into the partial remainder and try subtracting
  assign div_shift = {div_r, div_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, div_b};

  // Sign fix: quotient takes sign(a)^sign(b), remainder takes sign(a)
  assign q_fix   = div_neg_q ? (-div_q) : div_q;
  assign r_fix   = div_neg_r ? (-div_r) : div_r;
  assign div_res = div_is_rem ? r_fix : q_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      div_r      <= '0;
      div_b      <= '0;
      div_neg_q  <= 1'b0;
      div_neg_r  <= 1'b0;
      div_is_rem <= 1'b0;
      div_cnt    <= '0;
    end else if (div_start) begin
      div_q      <= a_abs;
      div_r      <= '0;
      div_b      <= b_abs;
      div_neg_q  <= div_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
      div_neg_r  <= div_signed && src_a[XLEN-1];
      div_is_rem <= div_rem_op;
      div_cnt    <= '0;
    end else if (state == S_BUSY) begin
      // Borrow out means the divisor did not fit: keep the shifted remainder
      if (div_trial[XLEN]) begin
        div_r <= div_shift[XLEN-1:0];
      end else begin
        div_r <= div_trial[XLEN-1:0];
      end
      div_q   <= {div_q[XLEN-2:0], ~div_trial[XLEN]};
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Control FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control FSM: next state, handshake and EX/MEM load strobe
  logic ex_load;

  always_comb begin
    state_nxt = state;
    ready4    = ready5;
    ex_load   = 1'b0;
    div_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid4 && div_go) begin
          ready4    = 1'b0;
          div_start = 1'b1;
          state_nxt = S_BUSY;
        end else begin
          ex_load = valid4 && ready5;
        end
      end
      S_BUSY: begin
        ready4 = 1'b0;
        if (div_cnt == CNT_W'(XLEN-1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Decode still presents the divide instruction while it is stalled
        ex_load = ready5;
        if (ready5) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Result select and forwarding
  // ------------------------------------------------------------------
  logic [XLEN-1:0] bpc_nxt;
  logic            br_take;

  assign result     = (state == S_DONE) ? div_res : alu_res;
  assign rdest1_    = rdest1;
  assign reg_w_en3_ = reg_w_en2 & valid4;

  assign bpc_nxt = PC4 + {{(XLEN-13){BImm2[11]}}, BImm2, 1'b0};
  assign br_take = ex_load && Brch2 && result[0];

  // ------------------------------------------------------------------
  // EX/MEM register and branch outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid5     <= 1'b0;
      PC5        <= '0;
      Ins4       <= '0;
      MEM_W_en3  <= 1'b0;
      WB_sel3    <= 1'b0;
      reg_w_en3  <= 1'b0;
      rt_data2   <= '0;
      rdest3     <= '0;
      ALU_res3   <= '0;
      Brch_taken <= 1'b0;
      BPC        <= '0;
    end else begin
      Brch_taken <= br_take;
      if (br_take) begin
        BPC <= bpc_nxt;
      end
      // MEM back-pressure freezes the whole bundle, valid included
      if (ready5) begin
        valid5 <= ex_load;
        if (ex_load) begin
          PC5       <= PC4;
          Ins4      <= Ins3;
          MEM_W_en3 <= MEM_W_en2;
          WB_sel3   <= WB_sel2;
          reg_w_en3 <= reg_w_en2;
          rt_data2  <= rt_data1;
          rdest3    <= rdest1;
          ALU_res3  <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041071_ex_stage
// Randomized and directed stimulus for the execute stage, checked against a
// behavioural model built from RV64 arithmetic on longint/int values.
// ----------------------------------------------------------------------------
module tb_ysyx_22041071_ex_stage;

  logic        clk;
  logic        reset;
  logic        valid4;
  logic        ready4;
  logic [63:0] PC4;
  logic [31:0] Ins3;
  logic        Brch2;
  logic        MEM_W_en2;
  logic        WB_sel2;
  logic [4:0]  ALU_ctrl2;
  logic        reg_w_en2;
  logic [63:0] rt_data1;
  logic [4:0]  rdest1;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic [11:0] BImm2;
  logic [63:0] result;
  logic [4:0]  rdest1_;
  logic        reg_w_en3_;
  logic        ready5;
  logic        valid5;
  logic [63:0] PC5;
  logic [31:0] Ins4;
  logic        MEM_W_en3;
  logic        WB_sel3;
  logic        reg_w_en3;
  logic [63:0] rt_data2;
  logic [4:0]  rdest3;
  logic [63:0] ALU_res3;
  logic        Brch_taken;
  logic [63:0] BPC;

  int total;
  int bad;

  ysyx_22041071_ex_stage dut (
    .clk        (clk),
    .reset      (reset),
    .valid4     (valid4),
    .ready4     (ready4),
    .PC4        (PC4),
    .Ins3       (Ins3),
    .Brch2      (Brch2),
    .MEM_W_en2  (MEM_W_en2),
    .WB_sel2    (WB_sel2),
    .ALU_ctrl2  (ALU_ctrl2),
    .reg_w_en2  (reg_w_en2),
    .rt_data1   (rt_data1),
    .rdest1     (rdest1),
    .src_a      (src_a),
    .src_b      (src_b),
    .BImm2      (BImm2),
    .result     (result),
    .rdest1_    (rdest1_),
    .reg_w_en3_ (reg_w_en3_),
    .ready5     (ready5),
    .valid5     (valid5),
    .PC5        (PC5),
    .Ins4       (Ins4),
    .MEM_W_en3  (MEM_W_en3),
    .WB_sel3    (WB_sel3),
    .reg_w_en3  (reg_w_en3),
    .rt_data2   (rt_data2),
    .rdest3     (rdest3),
    .ALU_res3   (ALU_res3),
    .Brch_taken (Brch_taken),
    .BPC        (BPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference ALU built from RV64 semantics
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    longint sa;
    longint sb;
    int     wa;
    int     wb;
    int     w;
    sa = a;
    sb = b;
    wa = a[31:0];
    wb = b[31:0];
    w  = 0;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[5:0];
      5'd3:  return (sa < sb) ? 64'd1 : 64'd0;
      5'd4:  return (a < b) ? 64'd1 : 64'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[5:0];
      5'd7:  return 64'(sa >>> b[5:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin w = wa + wb;                   return 64'(longint'(w)); end
      5'd11: begin w = wa - wb;                   return 64'(longint'(w)); end
      5'd12: begin w = wa << b[4:0];              return 64'(longint'(w)); end
      5'd13: begin w = int'(a[31:0] >> b[4:0]);   return 64'(longint'(w)); end
      5'd14: begin w = wa >>> b[4:0];             return 64'(longint'(w)); end
      5'd15: return a * b;
      5'd16: return (a == b) ? 64'd1 : 64'd0;
      5'd17: return (a != b) ? 64'd1 : 64'd0;
      5'd18: return (sa < sb) ? 64'd1 : 64'd0;
      5'd19: return (sa >= sb) ? 64'd1 : 64'd0;
      5'd20: return (a < b) ? 64'd1 : 64'd0;
      5'd21: return (a >= b) ? 64'd1 : 64'd0;
      5'd22: begin
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'h8000_0000_0000_0000;
        return 64'(sa / sb);
      end
      5'd23: return (b == 64'd0) ? '1 : (a / b);
      5'd24: begin
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return 64'(sa % sb);
      end
      5'd25: return (b == 64'd0) ? a : (a % b);
      default: return 64'd0;
    endcase
  endfunction

  // Branch offset {imm,0} as a signed byte count
  function automatic logic [63:0] br_off(input logic [11:0] imm);
    int v;
    v = int'(imm);
    if (v >= 2048) v = v - 4096;
    return 64'(longint'(v * 2));
  endfunction

  // Present one instruction, wait for acceptance, check forwarding and EX/MEM
  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic brch, input logic [11:0] imm, input logic [63:0] pc);
    logic [63:0] exp_res;
    logic [63:0] exp_bpc;
    logic        exp_taken;
    int          exp_stall;
    int          stall;
    logic [4:0]  rd;
    logic [31:0] ins;
    logic [63:0] rt;
    logic        wen;
    logic        wsel;
    logic        mw;
    rd        = 5'($urandom);
    ins       = $urandom | 32'h1;
    rt        = {$urandom, $urandom};
    wen       = 1'($urandom);
    wsel      = 1'($urandom);
    mw        = 1'($urandom);
    exp_res   = ref_alu(op, a, b);
    exp_taken = brch && (exp_res != 64'd0);
    exp_bpc   = pc + br_off(imm);
    exp_stall = (op >= 5'd22 && op <= 5'd25 && b != 64'd0) ? 65 : 0;

    @(negedge clk);
    valid4    = 1'b1;
    ALU_ctrl2 = op;
    src_a     = a;
    src_b     = b;
    Brch2     = brch;
    BImm2     = imm;
    PC4       = pc;
    Ins3      = ins;
    rdest1    = rd;
    rt_data1  = rt;
    reg_w_en2 = wen;
    WB_sel2   = wsel;
    MEM_W_en2 = mw;
    #1;
    stall = 0;
    while (!ready4 && stall < 200) begin
      @(negedge clk);
      #1;
      stall++;
    end
    chk("ready4", 64'(ready4), 64'd1);
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("result", result, exp_res);
    chk("fwd", 64'({reg_w_en3_, rdest1_}), 64'({wen, rd}));

    @(posedge clk);
    #1;
    chk("valid5", 64'(valid5), 64'd1);
    chk("alu_res3", ALU_res3, exp_res);
    chk("ctrl", 64'({MEM_W_en3, WB_sel3, reg_w_en3, rdest3}), 64'({mw, wsel, wen, rd}));
    chk("rt_data2", rt_data2, rt);
    chk("pc5", PC5, pc);
    chk("ins4", 64'(Ins4), 64'(ins));
    chk("brch_taken", 64'(Brch_taken), 64'(exp_taken));
    if (exp_taken) chk("bpc", BPC, exp_bpc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbr;
    int          sel;
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    valid4    = 1'b0;
    ready5    = 1'b1;
    PC4       = '0;
    Ins3      = '0;
    Brch2     = 1'b0;
    MEM_W_en2 = 1'b0;
    WB_sel2   = 1'b0;
    ALU_ctrl2 = '0;
    reg_w_en2 = 1'b0;
    rt_data1  = '0;
    rdest1    = '0;
    src_a     = '0;
    src_b     = '0;
    BImm2     = '0;
    #1 reset = 1'b1;
    #20;
    chk("rst_valid5", 64'(valid5), 64'd0);
    chk("rst_res3", ALU_res3, 64'd0);
    chk("rst_brch", 64'(Brch_taken), 64'd0);
    chk("rst_bpc", BPC, 64'd0);
    chk("rst_pc5", PC5, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    issue(5'd0,  64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 12'h000, 64'h8000_0000);
    issue(5'd14, 64'h8000_0000, 64'd4, 1'b0, 12'h000, 64'h8000_0004);
    issue(5'd16, 64'd7, 64'd7, 1'b1, 12'h008, 64'h8000_0100);
    issue(5'd17, 64'd7, 64'd7, 1'b1, 12'h008, 64'h8000_0104);
    issue(5'd19, 64'd3, 64'd9, 1'b1, 12'hFFE, 64'h8000_0200);
    issue(5'd18, 64'd3, 64'd9, 1'b1, 12'hFFE, 64'h8000_0204);
    issue(5'd22, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 12'h000, 64'h8000_0300);
    issue(5'd24, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 12'h000, 64'h8000_0304);
    issue(5'd23, 64'h1234, 64'd0, 1'b0, 12'h000, 64'h8000_0308);
    issue(5'd22, 64'h8000_0000_0000_0000, '1, 1'b0, 12'h000, 64'h8000_030C);
    issue(5'd0,  64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 12'h000, 64'h8000_0310);

    // MEM back-pressure holds the EX/MEM bundle
    @(negedge clk);
    ready5    = 1'b0;
    valid4    = 1'b1;
    ALU_ctrl2 = 5'd1;
    src_a     = 64'd10;
    src_b     = 64'd3;
    Brch2     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_res3", ALU_res3, 64'd2);
    chk("hold_valid5", 64'(valid5), 64'd1);
    chk("hold_ready4", 64'(ready4), 64'd0);
    @(negedge clk);
    ready5 = 1'b1;
    @(posedge clk);
    #1;
    chk("release_res3", ALU_res3, 64'd7);
    chk("release_valid5", 64'(valid5), 64'd1);
    @(negedge clk);
    valid4 = 1'b0;
    @(posedge clk);
    #1;
    chk("bubble_valid5", 64'(valid5), 64'd0);
    chk("bubble_res3", ALU_res3, 64'd7);

    // Divide result waiting in DONE while MEM is stalled
    @(negedge clk);
    valid4    = 1'b1;
    ALU_ctrl2 = 5'd22;
    src_a     = 64'd100;
    src_b     = 64'hFFFF_FFFF_FFFF_FFF9;
    @(posedge clk);
    @(negedge clk);
    ready5 = 1'b0;
    repeat (70) @(negedge clk);
    #1;
    chk("done_ready4", 64'(ready4), 64'd0);
    chk("done_result", result, 64'hFFFF_FFFF_FFFF_FFF2);
    chk("done_valid5", 64'(valid5), 64'd0);
    chk("done_res3", ALU_res3, 64'd7);
    ready5 = 1'b1;
    @(posedge clk);
    #1;
    chk("done_out_res3", ALU_res3, 64'hFFFF_FFFF_FFFF_FFF2);
    chk("done_out_valid5", 64'(valid5), 64'd1);
    @(negedge clk);
    valid4 = 1'b0;

    // Reset while the divider is busy
    @(negedge clk);
    valid4    = 1'b1;
    ALU_ctrl2 = 5'd23;
    src_a     = 64'd1000;
    src_b     = 64'd3;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("busy_rst_valid5", 64'(valid5), 64'd0);
    chk("busy_rst_res3", ALU_res3, 64'd0);
    chk("busy_rst_pc5", PC5, 64'd0);
    valid4 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("busy_rst_ready4", 64'(ready4), 64'd1);
    issue(5'd0, 64'd40, 64'd2, 1'b0, 12'h000, 64'h8000_0400);

    // Randomized instruction stream
    for (int i = 0; i < 120; i++) begin
      rop = 5'($urandom_range(0, 27));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 64'd0;
        1: begin ra = 64'h8000_0000_0000_0000; rb = '1; end
        2: rb = 64'($urandom_range(1, 100));
        3: rb = ra;
        4: rb = 64'd0 - 64'($urandom_range(1, 100));
        default: ;
      endcase
      rbr = (rop >= 5'd16 && rop <= 5'd21) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(rop, ra, rb, rbr, 12'($urandom), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
